arb_rr_front: RTL and testbench



---
 rtl/arb_rr_front_if.sv | 33 +++
 rtl/arb_rr_front.sv | 142 ++++++++++++++
 tb/tb_arb_rr_front.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_rr_front_if.sv
// Stream bundle between the round-robin front-end, its requesters, the combinational
// arbiter and the output consumer. master = front-end view, slave = environment view.
interface arb_rr_front_if #(
    parameter int unsigned REQ_NUM    = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned ID_W = $clog2(REQ_NUM);

    logic [REQ_NUM-1:0]            in_valid;
    logic [REQ_NUM-1:0]            in_ready;
    logic [REQ_NUM*DATA_WIDTH-1:0] in_data;
    logic [REQ_NUM-1:0]            in_last;
    logic [REQ_NUM-1:0]            arb_req;
    logic [REQ_NUM-1:0]            arb_priority;
    logic [REQ_NUM*DATA_WIDTH-1:0] arb_data_in;
    logic [REQ_NUM-1:0]            arb_gnt;
    logic [DATA_WIDTH-1:0]         arb_data_out;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_last;
    logic [ID_W-1:0]               out_id;

    modport master (
        input  in_valid, in_data, in_last, arb_gnt, arb_data_out, out_ready,
        output in_ready, arb_req, arb_priority, arb_data_in, out_valid, out_data, out_last, out_id
    );

    modport slave (
        output in_valid, in_data, in_last, arb_gnt, arb_data_out, out_ready,
        input  in_ready, arb_req, arb_priority, arb_data_in, out_valid, out_data, out_last, out_id
    );
endinterface

// File: rtl/arb_rr_front.sv
// Round-robin front-end for a combinational fixed-priority arbiter: per-requester 2-deep
// FIFOs, rotating thermometer priority, registered output. Optional packet lock: ARB_RR_PKT_LOCK_EN.
module arb_rr_front #(
    parameter int unsigned REQ_NUM    = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    arb_rr_front_if.master bus
);
    localparam int unsigned ID_W = $clog2(REQ_NUM);

    typedef logic [DATA_WIDTH:0] entry_t;  // {last, data}

    entry_t                        mem_q   [REQ_NUM][2];
    logic [1:0]                    count_q [REQ_NUM];
    logic [1:0]                    count_d [REQ_NUM];
    logic [REQ_NUM-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [REQ_NUM-1:0]            ready, push, pop, req, gnt_eff, head_last;
    logic [REQ_NUM-1:0]            lock_mask, prio_q, prio_rot;
    logic [REQ_NUM*DATA_WIDTH-1:0] data_in;
    logic [ID_W-1:0]               gnt_idx, out_id_q;
    logic                          accept, rotate, head_last_g;
    logic                          out_valid_q, out_last_q;
    logic [DATA_WIDTH-1:0]         out_data_q;

    always_comb begin
        ready     = '0;
        push      = '0;
        req       = '0;
        head_last = '0;
        data_in   = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            ready[i]     = (count_q[i] != 2'd2);
            push[i]      = bus.in_valid[i] & ready[i];
            req[i]       = (count_q[i] != 2'd0) & lock_mask[i];
            head_last[i] = mem_q[i][rd_ptr_q[i]][DATA_WIDTH];
            data_in[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_ptr_q[i]][DATA_WIDTH-1:0];
        end
    end

    // A grant for a requester that is not asking is ignored.
    assign gnt_eff     = bus.arb_gnt & req;
    assign accept      = (|req) & (~out_valid_q | bus.out_ready);
    assign pop         = accept ? gnt_eff : '0;
    assign head_last_g = head_last[gnt_idx];

    always_comb begin
        gnt_idx  = '0;
        prio_rot = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            if (gnt_eff[i]) gnt_idx = ID_W'(i);
        end
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            prio_rot[i] = (i > 32'(gnt_idx));
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            count_d[i] = count_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
        end
    end

`ifdef ARB_RR_PKT_LOCK_EN
    logic            lock_vld_q;
    logic [ID_W-1:0] lock_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
        end else if (accept) begin
            lock_vld_q <= ~head_last_g;
            if (!head_last_g) lock_id_q <= gnt_idx;
        end
    end

    always_comb begin
        lock_mask = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            lock_mask[i] = ~lock_vld_q | (lock_id_q == ID_W'(i));
        end
    end

    assign rotate = accept & head_last_g;
`else
    assign lock_mask = '1;
    assign rotate    = accept;
`endif

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {bus.in_last[i], bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < REQ_NUM; i++) count_q[i] <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int unsigned i = 0; i < REQ_NUM; i++) count_q[i] <= count_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
            prio_q      <= '1;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.arb_data_out;
                out_last_q  <= head_last_g;
                out_id_q    <= gnt_idx;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (rotate) prio_q <= prio_rot;
        end
    end

    assign bus.in_ready     = ready;
    assign bus.arb_req      = req;
    assign bus.arb_priority = prio_q;
    assign bus.arb_data_in  = data_in;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_id       = out_id_q;
endmodule

// File: tb/tb_arb_rr_front.sv
// Directed bench for arb_rr_front with a behavioural thermometer-priority arbiter model.
module tb_arb_rr_front;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    arb_rr_front_if #(.REQ_NUM(4), .DATA_WIDTH(8)) bus ();

    arb_rr_front #(.REQ_NUM(4), .DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Arbiter model: among requests whose priority bit is set, lowest index wins;
    // if none, lowest requesting index wins.
    logic [3:0] gnt_m;
    logic [7:0] dout_m;
    logic       done_m;
    always_comb begin
        gnt_m  = '0;
        dout_m = '0;
        done_m = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!done_m && bus.arb_req[i] && bus.arb_priority[i]) begin
                gnt_m[i] = 1'b1;
                done_m   = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!done_m && bus.arb_req[i]) begin
                gnt_m[i] = 1'b1;
                done_m   = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (gnt_m[i]) dout_m = bus.arb_data_in[8*i +: 8];
        end
    end
    assign bus.arb_gnt      = gnt_m;
    assign bus.arb_data_out = dout_m;

    int id_log[$];
    int data_log[$];
    int cyc_log[$];
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            id_log.push_back(int'(bus.out_id));
            data_log.push_back(int'(bus.out_data));
            cyc_log.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = '0;
        step();
        rst = 1'b0;
        id_log.delete();
        data_log.delete();
        cyc_log.delete();
    endtask

    function automatic logic [31:0] log_at(input int q[$], input int k);
        return (k < q.size()) ? 32'(q[k]) : 32'hDEAD;
    endfunction

    int exp_ids[6];
    int exp_dat[4];
    logic rdy;
    logic took;

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_last   = '0;
        bus.out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
        check_eq("rst_out_last", 32'(bus.out_last), 32'd0);
        check_eq("rst_out_id", 32'(bus.out_id), 32'd0);
        check_eq("rst_priority", 32'(bus.arb_priority), 32'hF);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'hF);
        check_eq("rst_arb_req", 32'(bus.arb_req), 32'h0);

        // Single beat from requester 2.
        bus.out_ready = 1'b1;
        bus.in_valid = 4'b0100;
        bus.in_last  = 4'b0100;
        bus.in_data[16 +: 8] = 8'hA1;
        step();
        bus.in_valid = '0;
        check_eq("t1_arb_req", 32'(bus.arb_req), 32'h4);
        check_eq("t1_valid_early", 32'(bus.out_valid), 32'd0);
        step();
        check_eq("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t1_out_data", 32'(bus.out_data), 32'hA1);
        check_eq("t1_out_id", 32'(bus.out_id), 32'd2);
        check_eq("t1_out_last", 32'(bus.out_last), 32'd1);
        check_eq("t1_priority", 32'(bus.arb_priority), 32'b1000);
        step();
        check_eq("t1_valid_drop", 32'(bus.out_valid), 32'd0);

        // All four requesters streaming single-beat packets.
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid = 4'b1111;
        bus.in_last  = 4'b1111;
        bus.in_data  = 32'h33221100;
        repeat (10) step();
        bus.in_valid = '0;
        repeat (10) step();
        exp_ids = '{0, 1, 2, 3, 0, 1};
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("t2_id%0d", k), log_at(id_log, k), 32'(exp_ids[k]));
        end
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("t2_gap%0d", k), log_at(cyc_log, k + 1) - log_at(cyc_log, k),
                     32'd1);
        end

        // Back-pressure on requester 1.
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid = 4'b0010;
        bus.in_last  = 4'b0010;
        bus.in_data[8 +: 8] = 8'h10;
        step();
        bus.in_data[8 +: 8] = 8'h11;
        step();
        bus.in_data[8 +: 8] = 8'h12;
        step();
        bus.in_data[8 +: 8] = 8'h13;
        check_eq("t3_in_ready_full", 32'(bus.in_ready), 32'b1101);
        check_eq("t3_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t3_out_data", 32'(bus.out_data), 32'h10);
        step();
        check_eq("t3_in_ready_hold", 32'(bus.in_ready), 32'b1101);
        check_eq("t3_out_data_hold", 32'(bus.out_data), 32'h10);
        check_eq("t3_out_id_hold", 32'(bus.out_id), 32'd1);
        bus.out_ready = 1'b1;
        took = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rdy = bus.in_ready[1];
            step();
            if (rdy) begin
                took = 1'b1;
                break;
            end
        end
        bus.in_valid = '0;
        check_eq("t3_fourth_taken", 32'(took), 32'd1);
        repeat (6) step();
        check_eq("t3_drain_len", 32'(data_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("t3_data%0d", k), log_at(data_log, k), 32'h10 + 32'(k));
        end

        // Three-beat packet on 0 against one beat on 1.
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid = 4'b0011;
        bus.in_last  = 4'b0010;
        bus.in_data[0 +: 8] = 8'hB0;
        bus.in_data[8 +: 8] = 8'hC0;
        step();
        bus.in_valid = 4'b0001;
        bus.in_last  = 4'b0000;
        bus.in_data[0 +: 8] = 8'hB1;
        step();
        bus.in_last  = 4'b0001;
        bus.in_data[0 +: 8] = 8'hB2;
        step();
        bus.in_valid = '0;
        repeat (6) step();
`ifdef ARB_RR_PKT_LOCK_EN
        exp_ids[0:3] = '{0, 0, 0, 1};
        exp_dat = '{'hB0, 'hB1, 'hB2, 'hC0};
`else
        exp_ids[0:3] = '{0, 1, 0, 0};
        exp_dat = '{'hB0, 'hC0, 'hB1, 'hB2};
`endif
        check_eq("t4_len", 32'(id_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("t4_id%0d", k), log_at(id_log, k), 32'(exp_ids[k]));
            check_eq($sformatf("t4_data%0d", k), log_at(data_log, k), 32'(exp_dat[k]));
        end

        // Wrap-around after requester 3.
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid = 4'b1000;
        bus.in_last  = 4'b1000;
        bus.in_data[24 +: 8] = 8'hD3;
        step();
        bus.in_valid = '0;
        step();
        check_eq("t5_out_id3", 32'(bus.out_id), 32'd3);
        check_eq("t5_priority_wrap", 32'(bus.arb_priority), 32'b0000);
        bus.in_valid = 4'b1001;
        bus.in_last  = 4'b1001;
        bus.in_data[0 +: 8]  = 8'hE0;
        bus.in_data[24 +: 8] = 8'hE3;
        step();
        bus.in_valid = '0;
        check_eq("t5_arb_req", 32'(bus.arb_req), 32'b1001);
        step();
        check_eq("t5_win_id", 32'(bus.out_id), 32'd0);
        check_eq("t5_win_data", 32'(bus.out_data), 32'hE0);
        step();
        check_eq("t5_second_id", 32'(bus.out_id), 32'd3);

        // Reset in the middle of a packet.
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid = 4'b0001;
        bus.in_last  = 4'b0000;
        bus.in_data[0 +: 8] = 8'hF0;
        step();
        bus.in_data[0 +: 8] = 8'hF1;
        step();
        bus.in_data[0 +: 8] = 8'hF2;
        step();
        bus.in_valid = '0;
        check_eq("t6_pre_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        id_log.delete();
        check_eq("t6_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("t6_priority", 32'(bus.arb_priority), 32'hF);
        check_eq("t6_in_ready", 32'(bus.in_ready), 32'hF);
        check_eq("t6_arb_req", 32'(bus.arb_req), 32'h0);
        bus.out_ready = 1'b1;
        bus.in_valid = 4'b0100;
        bus.in_last  = 4'b0100;
        bus.in_data[16 +: 8] = 8'h2A;
        step();
        bus.in_valid = '0;
        step();
        check_eq("t6_new_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t6_new_id", 32'(bus.out_id), 32'd2);
        check_eq("t6_new_data", 32'(bus.out_data), 32'h2A);
        repeat (4) step();
        check_eq("t6_log_len", 32'(id_log.size()), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
